// File: rtl/soc_bus_pkg.sv
// Shared definitions for the soc_bus two-master arbiter: FSM state encoding and
// the data pattern returned to a master whose transfer was aborted by the watchdog.
package soc_bus_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Wide enough for any data width in use; consumers slice off DW bits.
   localparam logic [63:0] BUS_ERR_DATA = '1;

endpackage

// File: rtl/arb_rr_pick2.sv
// Two-requester round-robin pick. Purely combinational: given the request pair
// and the index of the master served last, returns a one-hot grant (00 when no
// request is present).
module arb_rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // A tie goes to the master that was not served last.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter in front of the soc_bus master port.
// Master 0 is the CPU, master 1 a DMA/debug requester. A grant is registered in
// IDLE and held for one whole transfer in BUSY until the slave returns ready.
// Optional feature: define ARB_WATCHDOG_EN to abort transfers that see no
// s_ready for TIMEOUT BUSY cycles (sticky err_timeout flag).
module soc_bus_arbiter
   import soc_bus_pkg::*;
#(
   parameter int unsigned AW      = 8,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_we,
   input  logic          m0_valid,
   output logic          m0_ready,
   output logic [DW-1:0] m0_rdata,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_we,
   input  logic          m1_valid,
   output logic          m1_ready,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   output logic          s_we,
   output logic          s_valid,
   input  logic          s_ready,
   input  logic [DW-1:0] s_rdata,
   output logic [1:0]    grant,
   output logic          err_timeout
);

   if (TIMEOUT < 2) begin : g_timeout_check
      $error("soc_bus_arbiter: TIMEOUT must be at least 2");
   end

   arb_state_e    state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic          last_q, last_d;
   logic [1:0]    pick;
   logic          g_sel;
   logic          g_valid;
   logic          wd_fire;
   logic [DW-1:0] ret_data;

   assign g_sel   = grant_q[1];
   assign g_valid = g_sel ? m1_valid : m0_valid;
   assign grant   = grant_q;

   arb_rr_pick2 u_pick (
      .req  ({m1_valid, m0_valid}),
      .last (last_q),
      .gnt  (pick)
   );

`ifdef ARB_WATCHDOG_EN
   localparam int unsigned     CW      = $clog2(TIMEOUT);
   localparam logic [CW-1:0]   CntLast = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic          err_q;

   assign wd_fire     = (state_q == ST_BUSY) && g_valid && !s_ready && (cnt_q == CntLast);
   assign err_timeout = err_q;

   // Watchdog: count BUSY cycles without ready; held at zero outside BUSY.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q != ST_BUSY) cnt_q <= '0;
         else if (!s_ready)      cnt_q <= cnt_q + CW'(1);
         if (wd_fire)            err_q <= 1'b1;
      end
   end
`else
   assign wd_fire     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // State register: FSM state, current owner and last-served master.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Next state, bus mux and per-master responses.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      s_valid  = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      s_we     = 1'b0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
      ret_data = s_ready ? s_rdata : BUS_ERR_DATA[DW-1:0];
      unique case (state_q)
         ST_IDLE: begin
            if (pick != 2'b00) begin
               grant_d = pick;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            s_addr  = g_sel ? m1_addr  : m0_addr;
            s_wdata = g_sel ? m1_wdata : m0_wdata;
            s_we    = g_sel ? m1_we    : m0_we;
            if (!g_valid) begin
               // Owner withdrew its request: drop the bus, keep last unchanged.
               grant_d = 2'b00;
               state_d = ST_IDLE;
            end else begin
               s_valid = !wd_fire;
               if (s_ready || wd_fire) begin
                  // Responses are suppressed while reset is asserted.
                  if (rst_n) begin
                     m0_ready = !g_sel;
                     m1_ready = g_sel;
                     m0_rdata = g_sel ? '0 : ret_data;
                     m1_rdata = g_sel ? ret_data : '0;
                  end
                  last_d  = g_sel;
                  grant_d = 2'b00;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Self-checking bench for soc_bus_arbiter: reset values, first-transfer timing,
// a vector table of request patterns with a transaction scoreboard, reset in the
// middle of a transfer, owner dropping valid, and (with ARB_WATCHDOG_EN) timeout.
module tb_soc_bus_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] m0_addr, m1_addr, s_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
   logic          m0_we, m1_we, s_we;
   logic          m0_valid, m1_valid, s_valid;
   logic          m0_ready, m1_ready, s_ready;
   logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
   logic [1:0]    grant;
   logic          err_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   soc_bus_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0_addr     (m0_addr),
      .m0_wdata    (m0_wdata),
      .m0_we       (m0_we),
      .m0_valid    (m0_valid),
      .m0_ready    (m0_ready),
      .m0_rdata    (m0_rdata),
      .m1_addr     (m1_addr),
      .m1_wdata    (m1_wdata),
      .m1_we       (m1_we),
      .m1_valid    (m1_valid),
      .m1_ready    (m1_ready),
      .m1_rdata    (m1_rdata),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_we        (s_we),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_rdata     (s_rdata),
      .grant       (grant),
      .err_timeout (err_timeout)
   );

   // Slave model: ready after sl_lat wait cycles of an owned bus; data = addr ^ 0x4A.
   int   sl_lat = 1;
   int   sl_cnt = 0;
   logic sl_en  = 1'b1;

   always @(posedge clk) begin
      if (grant == 2'b00 || s_ready) sl_cnt <= 0;
      else                           sl_cnt <= sl_cnt + 1;
   end

   assign s_ready = sl_en && (grant != 2'b00) && (sl_cnt >= sl_lat);
   assign s_rdata = s_addr ^ 8'h4A;

   typedef struct {
      int         master;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } exp_t;

   typedef struct {
      logic       v0;
      logic       we0;
      logic [7:0] a0;
      logic [7:0] d0;
      logic       v1;
      logic       we1;
      logic [7:0] a1;
      logic [7:0] d1;
      int         lat;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[8];
   bit   exp_last = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int m, input logic we, input logic [7:0] a,
                               input logic [7:0] d);
      exp_t e;
      e.master = m;
      e.we     = we;
      e.addr   = a;
      e.wdata  = d;
      e.rdata  = a ^ 8'h4A;
      return e;
   endfunction

   // Scoreboard: every ready pops the oldest expected transfer.
   always @(negedge clk) begin
      if (m0_ready || m1_ready) begin
         chk("ready_onehot", {31'd0, m0_ready & m1_ready}, 0);
         chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("sb_master", m1_ready ? 1 : 0, mon_e.master);
            chk("sb_rdata", m1_ready ? m1_rdata : m0_rdata, mon_e.rdata);
            chk("sb_other_rdata", m1_ready ? m0_rdata : m1_rdata, 0);
            chk("sb_addr", s_addr, mon_e.addr);
            chk("sb_we", s_we, mon_e.we);
            if (mon_e.we) chk("sb_wdata", s_wdata, mon_e.wdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n    = 1'b1;
      exp_last = 1'b1;
   endtask

   // Wait for the requested masters to complete, dropping valid after each ready.
   task automatic wait_done(input logic v0, input logic v1);
      logic d0 = 1'b0;
      logic d1 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if ((d0 == v0) && (d1 == v1)) break;
         @(negedge clk);
         if (m0_ready) d0 = 1'b1;
         if (m1_ready) d1 = 1'b1;
         step();
         if (d0) m0_valid = 1'b0;
         if (d1) m1_valid = 1'b0;
      end
      chk("done", {30'd0, d1, d0}, {30'd0, v1, v0});
   endtask

   task automatic run_vec(input vec_t v);
      bit first;
      sl_lat   = v.lat;
      m0_valid = v.v0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_valid = v.v1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
      if (v.v0 && v.v1) begin
         first = !exp_last;
         if (first) begin
            sb.push_back(mk(1, v.we1, v.a1, v.d1));
            sb.push_back(mk(0, v.we0, v.a0, v.d0));
         end else begin
            sb.push_back(mk(0, v.we0, v.a0, v.d0));
            sb.push_back(mk(1, v.we1, v.a1, v.d1));
         end
         exp_last = !first;
      end else if (v.v0) begin
         sb.push_back(mk(0, v.we0, v.a0, v.d0));
         exp_last = 1'b0;
      end else if (v.v1) begin
         sb.push_back(mk(1, v.we1, v.a1, v.d1));
         exp_last = 1'b1;
      end
      wait_done(v.v0, v.v1);
      step();
   endtask

   initial begin
      exp_t e;
      m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

      vecs[0] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 1};
      vecs[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 1'b0, 8'h23, 8'h00, 2};
      vecs[2] = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 1'b0, 8'h25, 8'h00, 1};
      vecs[3] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b1, 1'b0, 8'h27, 8'h00, 1};
      vecs[4] = '{1'b1, 1'b1, 8'h30, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1};
      vecs[5] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h80, 8'h33, 1};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h55, 8'h00, 3};
      vecs[7] = '{1'b1, 1'b1, 8'h60, 8'hA1, 1'b1, 1'b1, 8'h61, 8'hB2, 0};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_s_valid", s_valid, 0);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_s_wdata", s_wdata, 0);
      chk("rst_s_we", s_we, 0);
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_err", err_timeout, 0);
      step();
      rst_n = 1'b1;

      // Single m0 read of 0x10: grant at cycle 1, ready at cycle 2
      step();
      sl_lat = 1;
      m0_addr = 8'h10; m0_we = 1'b0; m0_valid = 1'b1;
      sb.push_back(mk(0, 1'b0, 8'h10, 8'h00));
      @(negedge clk);
      chk("t1_c0_grant", grant, 0);
      step();
      @(negedge clk);
      chk("t1_c1_grant", grant, 2'b01);
      chk("t1_c1_s_valid", s_valid, 1);
      chk("t1_c1_s_addr", s_addr, 8'h10);
      chk("t1_c1_m0_ready", m0_ready, 0);
      step();
      @(negedge clk);
      chk("t1_c2_m0_ready", m0_ready, 1);
      chk("t1_c2_m0_rdata", m0_rdata, 8'h5A);
      step();
      m0_valid = 1'b0;
      @(negedge clk);
      chk("t1_c3_grant", grant, 0);
      chk("t1_c3_m0_rdata", m0_rdata, 0);

      // Vector table from a fresh reset
      step();
      do_reset();
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);
      chk("table_sb_empty", sb.size(), 0);

      // Reset on the second BUSY cycle of an m0 transfer
      sl_lat = 10;
      m0_addr = 8'h70; m0_we = 1'b0; m0_valid = 1'b1;
      step();
      @(negedge clk);
      chk("rm_busy1_grant", grant, 2'b01);
      step();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rm_busy2_m0_ready", m0_ready, 0);
      step();
      @(negedge clk);
      chk("rm_after_grant", grant, 0);
      chk("rm_after_s_valid", s_valid, 0);
      chk("rm_after_m0_ready", m0_ready, 0);
      step();
      rst_n    = 1'b1;
      exp_last = 1'b1;
      sl_lat   = 1;
      sb.push_back(mk(0, 1'b0, 8'h70, 8'h00));
      step();
      @(negedge clk);
      chk("rm_regrant", grant, 2'b01);
      wait_done(1'b1, 1'b0);
      exp_last = 1'b0;
      step();

      // Granted m1 drops valid mid-transfer while m0 waits
      sl_lat = 10;
      m0_addr = 8'h90; m0_we = 1'b0; m0_valid = 1'b1;
      m1_addr = 8'h91; m1_we = 1'b0; m1_valid = 1'b1;
      step();
      @(negedge clk);
      chk("dv_grant_m1", grant, 2'b10);
      step();
      m1_valid = 1'b0;
      @(negedge clk);
      chk("dv_s_valid", s_valid, 0);
      chk("dv_m1_ready", m1_ready, 0);
      step();
      @(negedge clk);
      chk("dv_idle_grant", grant, 0);
      chk("dv_idle_m1_ready", m1_ready, 0);
      sl_lat = 1;
      sb.push_back(mk(0, 1'b0, 8'h90, 8'h00));
      step();
      @(negedge clk);
      chk("dv_grant_m0", grant, 2'b01);
      wait_done(1'b1, 1'b0);
      exp_last = 1'b0;
      step();

`ifdef ARB_WATCHDOG_EN
      // Watchdog: slave never answers, abort on the 4th BUSY cycle
      chk("wd_err_before", err_timeout, 0);
      sl_en = 1'b0;
      m0_addr = 8'hC0; m0_we = 1'b0; m0_valid = 1'b1;
      e = mk(0, 1'b0, 8'hC0, 8'h00);
      e.rdata = 8'hFF;
      sb.push_back(e);
      for (int c = 1; c <= 3; c++) begin
         step();
         @(negedge clk);
         chk("wd_grant", grant, 2'b01);
         chk("wd_no_ready", m0_ready, 0);
      end
      step();
      @(negedge clk);
      chk("wd_ready", m0_ready, 1);
      chk("wd_rdata", m0_rdata, 8'hFF);
      chk("wd_s_valid", s_valid, 0);
      step();
      m0_valid = 1'b0;
      @(negedge clk);
      chk("wd_err_set", err_timeout, 1);
      chk("wd_idle", grant, 0);
      repeat (3) step();
      @(negedge clk);
      chk("wd_err_sticky", err_timeout, 1);
      sl_en = 1'b1;
`else
      chk("no_wd_err", err_timeout, 0);
`endif

      chk("final_sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
